// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the trafficlight controller and the lamp drivers.
// Unsafe lamp patterns are forced to all-red; a persistent fault latches a red flash until cleared.
module traffic_conflict_monitor #(
    parameter int FAULT_PERSIST  = 2,
    parameter int FLASH_HALF     = 1,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r1,
    input  logic       y1,
    input  logic       g1,
    input  logic       r2,
    input  logic       y2,
    input  logic       g2,
    input  logic       clear_fault,
    output logic       lamp_r1,
    output logic       lamp_y1,
    output logic       lamp_g1,
    output logic       lamp_r2,
    output logic       lamp_y2,
    output logic       lamp_g2,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int PW = $clog2(FAULT_PERSIST + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [PW-1:0] PERSIST_MAX  = PW'(FAULT_PERSIST);
    localparam logic [PW-1:0] PERSIST_LAST = PW'(FAULT_PERSIST - 1);
    localparam logic [FW-1:0] FLASH_MAX    = FW'(FLASH_HALF);
    localparam logic [RW-1:0] RECOVER_LAST = RW'(RECOVER_CYCLES - 1);
    localparam logic [5:0]    ALL_RED      = 6'b100_100;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] persist_cnt_r;
    logic [FW-1:0] flash_cnt_r;
    logic [RW-1:0] recover_cnt_r;
    logic [5:0]    lamps_r;
    logic          fault_r;
    logic [2:0]    fault_code_r;

    logic [5:0] cmd_s;
    logic       conflict_s;
    logic       multi_s;
    logic       dark_s;
    logic       bad_s;
    logic       trip_s;

    function automatic logic head_multi(input logic [2:0] h);
        return (h[2] & h[1]) | (h[2] & h[0]) | (h[1] & h[0]);
    endfunction

    function automatic logic head_dark(input logic [2:0] h);
        return ~|h;
    endfunction

    // Classify the incoming command pattern and decide whether this edge trips the fault.
    always_comb begin
        cmd_s      = {r1, y1, g1, r2, y2, g2};
        conflict_s = (g1 | y1) & (g2 | y2);
        multi_s    = head_multi(cmd_s[5:3]) | head_multi(cmd_s[2:0]);
        dark_s     = head_dark(cmd_s[5:3]) | head_dark(cmd_s[2:0]);
        bad_s      = conflict_s | multi_s | dark_s;
        case (state_r)
            ST_NORMAL, ST_RECOVER: trip_s = bad_s & (FAULT_PERSIST == 1);
            ST_SUSPECT:            trip_s = bad_s & (persist_cnt_r >= PERSIST_LAST);
            default:               trip_s = 1'b0;
        endcase
    end

    // Supervisor FSM; lamp outputs take the value belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_NORMAL;
            persist_cnt_r <= '0;
            flash_cnt_r   <= '0;
            recover_cnt_r <= '0;
            lamps_r       <= ALL_RED;
            fault_r       <= 1'b0;
            fault_code_r  <= 3'b000;
        end else if (trip_s) begin
            state_r       <= ST_FAULT;
            persist_cnt_r <= PERSIST_MAX;
            flash_cnt_r   <= FW'(1);
            lamps_r       <= ALL_RED;
            fault_r       <= 1'b1;
            fault_code_r  <= {dark_s, multi_s, conflict_s};
        end else begin
            case (state_r)
                ST_NORMAL: begin
                    if (bad_s) begin
                        state_r       <= ST_SUSPECT;
                        persist_cnt_r <= PW'(1);
                        lamps_r       <= ALL_RED;
                    end else begin
                        persist_cnt_r <= '0;
                        lamps_r       <= cmd_s;
                    end
                end
                ST_SUSPECT: begin
                    if (bad_s) begin
                        if (persist_cnt_r < PERSIST_MAX) begin
                            persist_cnt_r <= persist_cnt_r + PW'(1);
                        end else begin
                            persist_cnt_r <= persist_cnt_r;
                        end
                        lamps_r <= ALL_RED;
                    end else begin
                        state_r       <= ST_NORMAL;
                        persist_cnt_r <= '0;
                        lamps_r       <= cmd_s;
                    end
                end
                ST_FAULT: begin
                    if (clear_fault && !bad_s) begin
                        state_r       <= ST_RECOVER;
                        persist_cnt_r <= '0;
                        recover_cnt_r <= '0;
                        lamps_r       <= ALL_RED;
                        fault_r       <= 1'b0;
                        fault_code_r  <= 3'b000;
                    end else if (flash_cnt_r >= FLASH_MAX) begin
                        flash_cnt_r <= FW'(1);
                        lamps_r     <= {~lamps_r[5], 2'b00, ~lamps_r[5], 2'b00};
                    end else begin
                        flash_cnt_r <= flash_cnt_r + FW'(1);
                        lamps_r     <= {lamps_r[5], 2'b00, lamps_r[5], 2'b00};
                    end
                end
                ST_RECOVER: begin
                    if (bad_s) begin
                        state_r       <= ST_SUSPECT;
                        persist_cnt_r <= PW'(1);
                        lamps_r       <= ALL_RED;
                    end else if (recover_cnt_r >= RECOVER_LAST) begin
                        state_r <= ST_NORMAL;
                        lamps_r <= cmd_s;
                    end else begin
                        recover_cnt_r <= recover_cnt_r + RW'(1);
                        lamps_r       <= ALL_RED;
                    end
                end
                default: begin
                    state_r       <= ST_NORMAL;
                    persist_cnt_r <= '0;
                    lamps_r       <= ALL_RED;
                    fault_r       <= 1'b0;
                    fault_code_r  <= 3'b000;
                end
            endcase
        end
    end

    assign {lamp_r1, lamp_y1, lamp_g1, lamp_r2, lamp_y2, lamp_g2} = lamps_r;
    assign fault      = fault_r;
    assign fault_code = fault_code_r;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: directed vectors push expected outputs, a monitor pops and compares.
module tb_traffic_conflict_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       r1 = 1'b1, y1 = 1'b0, g1 = 1'b0;
    logic       r2 = 1'b1, y2 = 1'b0, g2 = 1'b0;
    logic       clear_fault = 1'b0;
    logic       lamp_r1, lamp_y1, lamp_g1, lamp_r2, lamp_y2, lamp_g2;
    logic       fault;
    logic [2:0] fault_code;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic [9:0] exp_q[$];
    int         id_q[$];
    int         checks = 0;
    int         errors = 0;
    int         step_id = 0;

    traffic_conflict_monitor dut (
        .clk(clk), .reset(reset),
        .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2),
        .clear_fault(clear_fault),
        .lamp_r1(lamp_r1), .lamp_y1(lamp_y1), .lamp_g1(lamp_g1),
        .lamp_r2(lamp_r2), .lamp_y2(lamp_y2), .lamp_g2(lamp_g2),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Drive one vector ahead of the next rising edge and record the response expected after it.
    task automatic step(input logic rst, input logic clr, input logic [2:0] h1, input logic [2:0] h2,
                        input logic [2:0] e1, input logic [2:0] e2, input logic ef, input logic [2:0] ec);
        @(negedge clk);
        reset       = rst;
        clear_fault = clr;
        {r1, y1, g1} = h1;
        {r2, y2, g2} = h2;
        exp_q.push_back({e1, e2, ef, ec});
        id_q.push_back(step_id);
        step_id++;
    endtask

    // Monitor: compare the registered outputs just after each rising edge.
    initial begin
        logic [9:0] got;
        logic [9:0] want;
        int         id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                id   = id_q.pop_front();
                got  = {lamp_r1, lamp_y1, lamp_g1, lamp_r2, lamp_y2, lamp_g2, fault, fault_code};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL step%0d lamps/fault/code got %b want %b", id, got, want);
                end
            end
        end
    end

    initial begin
        logic [2:0] ph1[6];
        logic [2:0] ph2[6];
        int         waited;
        ph1 = '{G, Y, R, R, R, R};
        ph2 = '{R, R, R, G, Y, R};

        // Reset held two clocks, even with a conflicting command present.
        step(1'b1, 1'b0, G, G, R, R, 1'b0, 3'b000);
        step(1'b1, 1'b0, G, G, R, R, 1'b0, 3'b000);
        // Pass-through with one clock of latency.
        step(1'b0, 1'b0, G, R, G, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, Y, R, Y, R, 1'b0, 3'b000);
        // Single conflicting cycle: one all-red cycle, no fault.
        step(1'b0, 1'b0, G, G, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, R, G, R, G, 1'b0, 3'b000);
        step(1'b0, 1'b0, R, Y, R, Y, 1'b0, 3'b000);
        // Two conflicting cycles: fault latched with CONFLICT, red flashes 1,0,1,0.
        step(1'b0, 1'b0, G, G, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, G, G, R, R, 1'b1, 3'b001);
        step(1'b0, 1'b0, R, R, O, O, 1'b1, 3'b001);
        step(1'b0, 1'b0, R, R, R, R, 1'b1, 3'b001);
        step(1'b0, 1'b0, R, R, O, O, 1'b1, 3'b001);
        // Clear while dark is ignored; clear while safe enters three all-red cycles.
        step(1'b0, 1'b1, O, O, R, R, 1'b1, 3'b001);
        step(1'b0, 1'b1, R, R, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, G, R, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, Y, R, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, R, G, R, G, 1'b0, 3'b000);
        // MULTI-only trip, then reset mid-fault.
        step(1'b0, 1'b0, 3'b101, R, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, 3'b101, R, R, R, 1'b1, 3'b010);
        step(1'b0, 1'b0, 3'b101, R, O, O, 1'b1, 3'b010);
        step(1'b1, 1'b0, G, G, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, R, G, R, G, 1'b0, 3'b000);
        // Trip code comes from the trip cycle only (MULTI+DARK), then a bad during recovery.
        step(1'b0, 1'b0, G, G, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, 3'b011, O, R, R, 1'b1, 3'b110);
        step(1'b0, 1'b1, R, R, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, G, G, R, R, 1'b0, 3'b000);
        step(1'b0, 1'b0, R, G, R, G, 1'b0, 3'b000);
        // Normal trafficlight sequence for 200 clocks: pure pass-through, no fault.
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, ph1[i % 6], ph2[i % 6], ph1[i % 6], ph2[i % 6], 1'b0, 3'b000);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
